// File: rtl/csr_inc.sv
// -----------------------------------------------------------------------------
// csr_inc
// Shared CSR definitions used by decode and writeback CSR logic.
//   csr_write_func    : read-modify-write flavour (RW / RS / RC)
//   csr_input_sel     : source operand select (register or 5-bit immediate)
//   csr_params_t      : decoded CSR instruction controls
//   csr_ctrl_state_t  : csr_access_ctrl sequencer states
//   CSR_RO_ADDR_BITS  : csr_addr[11:10] pattern marking a read-only CSR
// -----------------------------------------------------------------------------
package csr_inc;

   typedef enum logic [1:0] {
      CSR_RW = 2'd0,
      CSR_RS = 2'd1,
      CSR_RC = 2'd2
   } csr_write_func;

   typedef enum logic {
      CSR_SEL_REG = 1'b0,
      CSR_SEL_IMM = 1'b1
   } csr_input_sel;

   typedef struct packed {
      logic          read_enable;
      logic          write_enable;
      csr_input_sel  input_select;
      csr_write_func write_func;
   } csr_params_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_WRITE   = 3'd2,
      ST_TRAP_WR = 3'd3,
      ST_DONE    = 3'd4
   } csr_ctrl_state_t;

   localparam logic [1:0] CSR_RO_ADDR_BITS = 2'b11;

endpackage

// File: rtl/csr_wdata_calc.sv
// -----------------------------------------------------------------------------
// csr_wdata_calc
// Combinational CSR write-data generator.
//   write_func : RW / RS / RC
//   old_value  : current CSR contents
//   src        : source operand (rs1 or zero-extended uimm)
//   wdata      : value to write back
// -----------------------------------------------------------------------------
module csr_wdata_calc
   import csr_inc::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  csr_write_func   write_func,
   input  logic [XLEN-1:0] old_value,
   input  logic [XLEN-1:0] src,
   output logic [XLEN-1:0] wdata
);

   always_comb begin
      wdata = src;
      case (write_func)
         CSR_RW:  wdata = src;
         CSR_RS:  wdata = old_value | src;
         CSR_RC:  wdata = old_value & ~src;
         default: wdata = src;
      endcase
   end

endmodule

// File: rtl/csr_access_ctrl.sv
// -----------------------------------------------------------------------------
// csr_access_ctrl
// Writeback-stage CSR sequencer: runs read / modify / write against the CSR
// file over a req/ack bus and arbitrates that bus with trap-unit writes.
//   clk, reset            : core clock, asynchronous active-high reset
//   start, csr_params,
//   csr_addr, rs1_value,
//   uimm                  : CSR instruction from writeback (taken when ready)
//   ready, done, rd_data,
//   illegal               : stall / completion / old value / reject status
//   trap_req, trap_addr,
//   trap_wdata, trap_ack  : trap-unit write port (req held until ack)
//   bus_req, bus_we,
//   bus_addr, bus_wdata,
//   bus_ack, bus_rdata,
//   bus_err               : CSR file bus (ack may arrive with req)
// -----------------------------------------------------------------------------
module csr_access_ctrl
   import csr_inc::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned CSR_ADDR_W = 12
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  start,
   input  csr_params_t           csr_params,
   input  logic [CSR_ADDR_W-1:0] csr_addr,
   input  logic [XLEN-1:0]       rs1_value,
   input  logic [4:0]            uimm,
   output logic                  ready,
   output logic                  done,
   output logic [XLEN-1:0]       rd_data,
   output logic                  illegal,

   input  logic                  trap_req,
   input  logic [CSR_ADDR_W-1:0] trap_addr,
   input  logic [XLEN-1:0]       trap_wdata,
   output logic                  trap_ack,

   output logic                  bus_req,
   output logic                  bus_we,
   output logic [CSR_ADDR_W-1:0] bus_addr,
   output logic [XLEN-1:0]       bus_wdata,
   input  logic                  bus_ack,
   input  logic [XLEN-1:0]       bus_rdata,
   input  logic                  bus_err
);

   csr_ctrl_state_t       state;
   csr_ctrl_state_t       state_n;
   logic                  ready_q;
   csr_params_t           params_q;
   logic [XLEN-1:0]       src_q;
   logic [XLEN-1:0]       old_q;
   logic                  illegal_q;
   logic [CSR_ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]       wdata_q;
   logic [XLEN-1:0]       calc_wdata;

   logic                  accept;
   logic                  trap_accept;
   logic                  ro_reject;
   logic                  needs_bus;

   assign trap_accept = (state == ST_IDLE) && trap_req;
   assign accept      = (state == ST_IDLE) && !trap_req && start;
   assign ro_reject   = csr_params.write_enable &&
                        (csr_addr[CSR_ADDR_W-1 -: 2] == CSR_RO_ADDR_BITS);
   assign needs_bus   = !ro_reject &&
                        (csr_params.read_enable || csr_params.write_enable);

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: begin
            if (trap_req) begin
               state_n = ST_TRAP_WR;
            end else if (start) begin
               if (ro_reject)                    state_n = ST_DONE;
               else if (csr_params.read_enable)  state_n = ST_READ;
               else if (csr_params.write_enable) state_n = ST_WRITE;
               else                              state_n = ST_DONE;
            end
         end
         ST_READ: begin
            if (bus_ack) begin
               if (bus_err)                    state_n = ST_DONE;
               else if (params_q.write_enable) state_n = ST_WRITE;
               else                            state_n = ST_DONE;
            end
         end
         ST_WRITE:   if (bus_ack) state_n = ST_DONE;
         ST_TRAP_WR: if (bus_ack) state_n = ST_IDLE;
         ST_DONE:    state_n = ST_IDLE;
         default:    state_n = ST_IDLE;
      endcase
   end

   csr_wdata_calc #(
      .XLEN (XLEN)
   ) u_wdata_calc (
      .write_func (params_q.write_func),
      .old_value  (old_q),
      .src        (src_q),
      .wdata      (calc_wdata)
   );

   // bus_addr/wdata live in registers so they hold their last value whenever
   // the bus is idle; only the WRITE-state data comes straight from the
   // calculator, and that depends on the old-value register, not bus_rdata.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         ready_q   <= 1'b1;
         params_q  <= '0;
         src_q     <= '0;
         old_q     <= '0;
         illegal_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state   <= state_n;
         ready_q <= (state_n == ST_IDLE);

         if (trap_accept) begin
            addr_q  <= trap_addr;
            wdata_q <= trap_wdata;
         end

         if (accept) begin
            params_q  <= csr_params;
            src_q     <= (csr_params.input_select == CSR_SEL_REG) ?
                         rs1_value : {{(XLEN-5){1'b0}}, uimm};
            old_q     <= '0;
            illegal_q <= ro_reject;
            if (needs_bus) addr_q <= csr_addr;
         end

         if (state == ST_READ && bus_ack) begin
            old_q <= bus_rdata;
            if (bus_err) illegal_q <= 1'b1;
         end

         if (state == ST_WRITE) begin
            wdata_q <= calc_wdata;
            if (bus_ack && bus_err) illegal_q <= 1'b1;
         end
      end
   end

   assign ready     = ready_q && !trap_req;
   assign done      = (state == ST_DONE);
   assign illegal   = (state == ST_DONE) && illegal_q;
   assign rd_data   = old_q;
   assign trap_ack  = (state == ST_TRAP_WR) && bus_ack;

   assign bus_req   = (state == ST_READ) || (state == ST_WRITE) ||
                      (state == ST_TRAP_WR);
   assign bus_we    = (state == ST_WRITE) || (state == ST_TRAP_WR);
   assign bus_addr  = addr_q;
   assign bus_wdata = (state == ST_WRITE) ? calc_wdata : wdata_q;

endmodule
